// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level constants for the I2C target and its helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK
    } i2c_state_t;

    // SDA levels as seen on the wire during the acknowledge slot.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // The general-call address (all zeros) is never claimed.
    function automatic logic addr_match(input logic [6:0] rcvd, input logic [6:0] own);
        return (rcvd == own) && (rcvd != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA pins and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   sclNow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclPrev_q <= sclSync_q[SYNC_STAGES-1];
            sdaPrev_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclNow   = sclSync_q[SYNC_STAGES-1];
    assign sda_s    = sdaSync_q[SYNC_STAGES-1];
    assign scl_rise = sclNow & ~sclPrev_q;
    assign scl_fall = ~sclNow & sclPrev_q;

    // SCL must be high on both samples so an SDA change next to an SCL edge is not misread.
    assign start = sclNow & sclPrev_q & sdaPrev_q & ~sda_s;
    assign stop  = sclNow & sclPrev_q & ~sdaPrev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: decodes address/data on the bus, acks writes and serves read bytes, no clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic sclRise;
    logic sclFall;
    logic sdaS;
    logic startSeen;
    logic stopSeen;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .resetn   (resetn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (sclRise),
        .scl_fall (sclFall),
        .sda_s    (sdaS),
        .start    (startSeen),
        .stop     (stopSeen)
    );

    i2c_state_t state_q;
    logic [6:0] shift_q;
    logic [2:0] bitCnt_q;
    logic       byteDone_q;
    logic       rw_q;
    logic       first_q;
    logic       ackBit_q;
    logic       sdaOe_q;
    logic [7:0] rxData_q;
    logic       rxValid_q;
    logic       rxFirst_q;
    logic       txReq_q;
    logic       startDet_q;
    logic       stopDet_q;
    logic       busy_q;

    logic [7:0] shiftIn;
    logic       lastBit;

    // Only seven bits are stored: on transmit the MSB goes straight to SDA when the byte is loaded.
    assign shiftIn = {shift_q, sdaS};
    assign lastBit = (bitCnt_q == 3'd7);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bitCnt_q   <= '0;
            byteDone_q <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            ackBit_q   <= NACK;
            sdaOe_q    <= 1'b0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            rxFirst_q  <= 1'b0;
            txReq_q    <= 1'b0;
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rxValid_q  <= 1'b0;
            txReq_q    <= 1'b0;
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;

            if (startSeen) begin
                startDet_q <= 1'b1;
                bitCnt_q   <= '0;
                byteDone_q <= 1'b0;
                sdaOe_q    <= 1'b0;
                state_q    <= S_ADDR;
            end else if (stopSeen) begin
                stopDet_q  <= 1'b1;
                byteDone_q <= 1'b0;
                sdaOe_q    <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        byteDone_q <= 1'b0;
                    end

                    S_ADDR: begin
                        if (sclRise && !byteDone_q) begin
                            shift_q  <= shiftIn[6:0];
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (lastBit) begin
                                if (addr_match(shiftIn[7:1], ADDR)) begin
                                    byteDone_q <= 1'b1;
                                    busy_q     <= 1'b1;
                                    rw_q       <= shiftIn[0];
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_IDLE;
                                end
                            end
                        end else if (sclFall && byteDone_q) begin
                            byteDone_q <= 1'b0;
                            sdaOe_q    <= 1'b1;
                            state_q    <= S_ADDR_ACK;
                        end
                    end

                    S_ADDR_ACK: begin
                        if (sclFall) begin
                            bitCnt_q <= '0;
                            if (!rw_q) begin
                                sdaOe_q <= 1'b0;
                                first_q <= 1'b1;
                                state_q <= S_RX;
                            end else begin
                                txReq_q <= 1'b1;
                                shift_q <= tx_data[6:0];
                                sdaOe_q <= ~tx_data[7];
                                state_q <= S_TX;
                            end
                        end
                    end

                    S_RX: begin
                        if (sclRise && !byteDone_q) begin
                            shift_q  <= shiftIn[6:0];
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (lastBit) begin
                                rxData_q   <= shiftIn;
                                rxValid_q  <= 1'b1;
                                rxFirst_q  <= first_q;
                                first_q    <= 1'b0;
                                byteDone_q <= 1'b1;
                            end
                        end else if (sclFall && byteDone_q) begin
                            byteDone_q <= 1'b0;
                            sdaOe_q    <= 1'b1;
                            state_q    <= S_RX_ACK;
                        end
                    end

                    S_RX_ACK: begin
                        if (sclFall) begin
                            bitCnt_q <= '0;
                            sdaOe_q  <= 1'b0;
                            state_q  <= S_RX;
                        end
                    end

                    S_TX: begin
                        if (sclFall) begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (lastBit) begin
                                sdaOe_q  <= 1'b0;
                                ackBit_q <= NACK;
                                state_q  <= S_TX_ACK;
                            end else begin
                                sdaOe_q <= ~shift_q[6];
                                shift_q <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end

                    S_TX_ACK: begin
                        if (sclRise) begin
                            ackBit_q <= sdaS;
                        end else if (sclFall) begin
                            bitCnt_q <= '0;
                            if (ackBit_q == ACK) begin
                                txReq_q <= 1'b1;
                                shift_q <= tx_data[6:0];
                                sdaOe_q <= ~tx_data[7];
                                state_q <= S_TX;
                            end else begin
                                sdaOe_q <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end

                    default: begin
                        sdaOe_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sdaOe_q;
    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign rx_first  = rxFirst_q;
    assign tx_req    = txReq_q;
    assign start_det = startDet_q;
    assign stop_det  = stopDet_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a behavioural I2C controller drives the bus at 100 kHz with a 16 MHz clk.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] TARGET = 7'h42;
    localparam time        Q      = 2500;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } rxExp_t;

    logic       clk;
    logic       resetn;
    logic       sclH;
    logic       sdaC;
    logic       sdaBus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    rxExp_t     expRxQ[$];
    logic [7:0] txSupplyQ[$];

    int assertCnt = 0;
    int failCnt   = 0;
    int startCnt  = 0;
    int stopCnt   = 0;
    int txReqCnt  = 0;
    int expStarts = 0;
    int expStops  = 0;
    int expTxReqs = 0;
    bit sdaOeSeen   = 0;
    bit watchBusy   = 0;
    bit busyDropped = 0;

    assign sdaBus = sdaC & ~sda_oe;

    i2c_target #(
        .ADDR        (TARGET),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .scl_i     (sclH),
        .sda_i     (sdaBus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #31.25 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit addrHit(input logic [7:0] a);
        return (a[7:1] == TARGET) && (a[7:1] != 7'd0);
    endfunction

    // Monitor: consumes DUT pulses, checks them against the queued expectations, feeds tx_data.
    always @(negedge clk) begin
        rxExp_t e;
        if (resetn) begin
            if (sda_oe) sdaOeSeen = 1'b1;
            if (watchBusy && !busy) busyDropped = 1'b1;
            if (start_det) startCnt++;
            if (stop_det) stopCnt++;
            if (rx_valid || tx_req) checkOutput("rxTxExclusive", {31'd0, rx_valid & tx_req}, 32'd0);
            if (rx_valid) begin
                if (expRxQ.size() != 0) begin
                    e = expRxQ.pop_front();
                    checkOutput("rxData", {24'd0, rx_data}, {24'd0, e.data});
                    checkOutput("rxFirst", {31'd0, rx_first}, {31'd0, e.first});
                end else begin
                    checkOutput("rxUnexpected", {23'd0, rx_first, rx_data}, 32'hFFFF_FFFF);
                end
            end
            if (tx_req) begin
                txReqCnt++;
                if (txSupplyQ.size() != 0) void'(txSupplyQ.pop_front());
                else checkOutput("txReqUnexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end
        end
        tx_data = (txSupplyQ.size() != 0) ? txSupplyQ[0] : 8'hFF;
    end

    task automatic i2cStart();
        sdaC = 1'b1; #(Q);
        sclH = 1'b1; #(Q);
        sdaC = 1'b0; #(Q);
        sclH = 1'b0; #(Q);
        expStarts++;
    endtask

    task automatic i2cStop();
        sdaC = 1'b0; #(Q);
        sclH = 1'b1; #(Q);
        sdaC = 1'b1; #(Q);
        expStops++;
    endtask

    task automatic writeBit(input logic b);
        sdaC = b;    #(Q);
        sclH = 1'b1; #(2 * Q);
        sclH = 1'b0; #(Q);
    endtask

    task automatic readBit(output logic b);
        sdaC = 1'b1; #(Q);
        sclH = 1'b1; #(Q);
        b = sdaBus;  #(Q);
        sclH = 1'b0; #(Q);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            readBit(b);
            d = {d[6:0], b};
        end
    endtask

    // One addressed transfer (no STOP); the reference model decides ACKs, rx bytes and read data.
    task automatic applyStimulus(input logic [7:0] addrByte, input logic [7:0] payload [4], input int n);
        logic       ack;
        logic [7:0] got;
        bit         hit;
        rxExp_t     e;
        hit = addrHit(addrByte);
        if (hit && addrByte[0]) begin
            for (int i = 0; i < n; i++) begin
                txSupplyQ.push_back(payload[i]);
                expTxReqs++;
            end
        end
        i2cStart();
        writeByte(addrByte, ack);
        checkOutput("addrAck", {31'd0, ack}, hit ? 32'd0 : 32'd1);
        checkOutput("busyAfterAddr", {31'd0, busy}, {31'd0, hit});
        if (!hit) return;
        for (int i = 0; i < n; i++) begin
            if (!addrByte[0]) begin
                e.data  = payload[i];
                e.first = (i == 0);
                expRxQ.push_back(e);
                writeByte(payload[i], ack);
                checkOutput("dataAck", {31'd0, ack}, 32'd0);
            end else begin
                readByte(got);
                checkOutput("readData", {24'd0, got}, {24'd0, payload[i]});
                writeBit(i == n - 1);
            end
        end
        if (addrByte[0]) begin
            checkOutput("sdaReleasedAfterNack", {31'd0, sda_oe}, 32'd0);
            checkOutput("busyAfterNack", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "StartCount"}, startCnt, expStarts);
        checkOutput({tag, "StopCount"}, stopCnt, expStops);
        checkOutput({tag, "TxReqCount"}, txReqCnt, expTxReqs);
        checkOutput({tag, "RxDrained"}, expRxQ.size(), 32'd0);
    endtask

    initial begin
        #(5_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] p [4];
        logic [7:0] a;
        logic       ack;
        logic       b;
        int         n;

        resetn = 1'b0;
        sclH   = 1'b1;
        sdaC   = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("resetOutputs", {17'd0, sda_oe, rx_data, rx_valid, rx_first, tx_req, start_det, stop_det, busy}, 32'd0);
        resetn = 1'b1;
        #(Q);

        $display("[TB] write 0x84 A5 3C");
        p = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        applyStimulus(8'h84, p, 2);
        i2cStop();
        checkOutput("writeBusyAfterStop", {31'd0, busy}, 32'd0);
        checkOutput("writeLastRx", {24'd0, rx_data}, 32'h3C);
        checkCounts("write");

        $display("[TB] read 0x85 96 01");
        p = '{8'h96, 8'h01, 8'h00, 8'h00};
        applyStimulus(8'h85, p, 2);
        i2cStop();
        checkCounts("read");

        $display("[TB] address mismatch 0x90");
        sdaOeSeen = 1'b0;
        p = '{8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h90, p, 0);
        i2cStop();
        checkOutput("missNeverDrives", {31'd0, sdaOeSeen}, 32'd0);
        checkOutput("missBusy", {31'd0, busy}, 32'd0);

        $display("[TB] repeated START");
        p = '{8'h10, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h84, p, 1);
        busyDropped = 1'b0;
        watchBusy   = 1'b1;
        p = '{8'hC3, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h85, p, 1);
        watchBusy = 1'b0;
        checkOutput("repStartBusyHeld", {31'd0, busyDropped}, 32'd0);
        checkOutput("repStartRxData", {24'd0, rx_data}, 32'h10);
        i2cStop();
        checkCounts("repStart");

        $display("[TB] abort mid-byte");
        i2cStart();
        writeByte(8'h84, ack);
        checkOutput("abortAddrAck", {31'd0, ack}, 32'd0);
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
        i2cStop();
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortSdaOe", {31'd0, sda_oe}, 32'd0);
        p = '{8'h55, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h84, p, 1);
        i2cStop();
        checkOutput("abortRecoverRx", {24'd0, rx_data}, 32'h55);
        checkCounts("abort");

        $display("[TB] reset during TX");
        txSupplyQ.push_back(8'h96);
        expTxReqs++;
        i2cStart();
        writeByte(8'h85, ack);
        checkOutput("rstAddrAck", {31'd0, ack}, 32'd0);
        readBit(b);
        checkOutput("rstFirstBit", {31'd0, b}, 32'd1);
        checkOutput("rstDrivingZero", {31'd0, sda_oe}, 32'd1);
        @(negedge clk);
        #7;
        resetn = 1'b0;
        #1;
        checkOutput("rstAsyncRelease", {31'd0, sda_oe}, 32'd0);
        checkOutput("rstOutputs", {17'd0, sda_oe, rx_data, rx_valid, rx_first, tx_req, start_det, stop_det, busy}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        expRxQ.delete();
        txSupplyQ.delete();
        sdaC = 1'b1;
        sclH = 1'b1;
        #(Q);
        p = '{8'h5A, 8'hE7, 8'h00, 8'h00};
        applyStimulus(8'h84, p, 2);
        i2cStop();
        checkCounts("postReset");

        $display("[TB] randomized transfers");
        for (int t = 0; t < 5; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h84;
                1:       a = 8'h85;
                default: a = 8'($urandom_range(0, 255));
            endcase
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) p[k] = 8'($urandom_range(0, 255));
            applyStimulus(a, p, n);
            i2cStop();
            checkOutput("randBusyAfterStop", {31'd0, busy}, 32'd0);
        end
        checkCounts("final");
        checkOutput("txSupplyDrained", txSupplyQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the SoC's I2C bus; the opposite end of the existing I2C master.
- Lets the tiny SoC act as a peripheral of an external controller, or loop back onto its own master for self-test.
- Samples the open-drain SCL and SDA pins and decodes START, STOP, address, data and ACK.
- Hands received bytes to a byte-wide local interface and sources read bytes from it.
- No clock stretching. Sits behind an iomem-mapped register wrapper in the top level.

Parameters:
- ADDR, 7'h42, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchroniser depth on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  system clock. Must be at least 16x the SCL frequency.
- resetn  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL pin input (raw, asynchronous).
- sda_i  in  1  SDA pin input (raw, asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release. The top level ties the pad output to 0.
- rx_data  out  8  last received data byte.
- rx_valid  out  1  one-cycle pulse when rx_data has been updated.
- rx_first  out  1  qualifies rx_valid: first data byte after an address match.
- tx_data  in  8  byte to transmit on a read. Sampled on the cycle tx_req is high.
- tx_req  out  1  one-cycle pulse; tx_data is captured in the same cycle.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from an address match until STOP, or until the next START that does not match.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, start_det=0, stop_det=0, busy=0, state=IDLE, synchronisers=1.
- Reset is asynchronous. Asserting it mid-transfer releases SDA immediately and returns to IDLE.
- Input path: SYNC_STAGES flops, then a registered copy used for edge detection. An edge is visible internally SYNC_STAGES+1 cycles after the pin changes.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Both are detected in every state and take priority over bit processing.
- START pulses start_det, clears the bit counter, releases sda_oe and goes to ADDR.
- STOP pulses stop_det, releases sda_oe, clears busy and goes to IDLE.
- Bits are sampled on the SCL rising edge. SDA is changed only on the cycle the SCL falling edge is detected.
- States:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits, MSB first. After the 8th rising edge, compares bits[7:1] with ADDR.
    - Match: on the next falling edge assert sda_oe and go to ADDR_ACK. Set busy, latch rw = bit0.
    - No match: go to IDLE and never drive SDA.
  - ADDR_ACK: on the falling edge ending the ACK bit:
    - rw=0: release SDA, go to RX, set the first flag.
    - rw=1: pulse tx_req, load the shift register from tx_data, drive sda_oe = ~tx_data[7], go to TX.
  - RX: shifts 8 bits. In the cycle after the 8th rising edge, update rx_data, pulse rx_valid, and set rx_first = first flag, then clear the first flag. On the next falling edge assert sda_oe (ACK) and go to RX_ACK.
  - RX_ACK: on the falling edge, release SDA and go to RX.
  - TX: on each falling edge, shift and drive sda_oe = ~next bit. After the 8th bit's falling edge, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the rising edge.
    - 0 (ACK): on the falling edge pulse tx_req, reload, drive the MSB, go to TX.
    - 1 (NACK): go to IDLE with SDA released; busy stays high until STOP.
- Bit counter: 3 bits, wraps 7 to 0 at each byte boundary.
- rx_valid and tx_req are never high in the same cycle.
- A STOP or START mid-byte discards the partial byte: no rx_valid, no tx_req.
- General call (address 0) is not supported and is treated as a mismatch.

Decomposition:
- Shared package i2c_pkg holds the state enum (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK) and the ACK/NACK level constants.
- One natural sub-module, i2c_line_sync: synchroniser plus edge detector. Outputs scl_rise, scl_fall, sda_s, start, stop. The same module can be reused by the existing master.

Test Plan:
- Write: START, 0x84, 0xA5, 0x3C, STOP at 100 kHz with a 16 MHz clk -> ACK on all 3 bytes; rx_valid twice with rx_data=0xA5 (rx_first=1), then 0x3C (rx_first=0); start_det and stop_det each pulse once.
- Read: START, 0x85, tx_data=0x96; controller ACKs, then tx_data=0x01 and the controller NACKs -> SDA carries 0x96 then 0x01; tx_req pulses twice; sda_oe=0 after the NACK.
- Mismatch: START, 0x90 -> sda_oe stays 0 for the whole transfer; busy=0; no rx_valid.
- Repeated START: write 0x84, 0x10, then repeated START, 0x85 -> rx_data=0x10, then a read begins with tx_req; start_det pulses twice; busy stays 1 throughout.
- Abort: STOP after 4 bits of a data byte -> no rx_valid, IDLE, busy=0. Then a full write of 0x84, 0x55 -> rx_data=0x55.
- Reset mid-TX while driving a 0 bit -> sda_oe=0 asynchronously, all outputs at reset values; the next transaction completes normally.
